// File: rtl/serial_add_seq.sv
// Digit-serial adder: {Carry,Sum} = A+B+Cin, one 2-bit digit per cycle, LSB digit first.
// Latency: done pulses NDIG (=WIDTH/2) cycles after the start edge; busy for those NDIG cycles.
// Backpressure: start is ignored while busy; accepted only in IDLE or in the one-cycle DONE state.

module full_adder_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {2'b00, ci};
endmodule

module serial_add_seq #(
  parameter int WIDTH = 8  // must be even and >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);
  localparam int NDIG = WIDTH / 2;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c_q;
  logic [IW-1:0]    idx_q;
  logic [1:0]       a_dig, b_dig, fa_s;
  logic             fa_co;
  logic             last_dig;
  logic             accept;

  assign last_dig = (idx_q == IW'(NDIG - 1));
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));

  // Digit select by comparison against each constant position keeps all slices static.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (idx_q == IW'(d)) begin
        a_dig = a_q[2*d +: 2];
        b_dig = b_q[2*d +: 2];
      end
    end
  end

  full_adder_2bit u_fa (
    .a  (a_dig),
    .b  (b_dig),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_dig) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        c_q   <= Cin;
        idx_q <= '0;
        sum_q <= '0;
      end else if (state_q == RUN) begin
        for (int d = 0; d < NDIG; d++) begin
          if (idx_q == IW'(d)) sum_q[2*d +: 2] <= fa_s;
        end
        // The inter-digit carry register doubles as the final Carry output.
        c_q <= fa_co;
        if (!last_dig) idx_q <= idx_q + IW'(1);
      end
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign Sum   = sum_q;
  assign Carry = c_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random checks of serial_add_seq at WIDTH=8 and WIDTH=2.
module tb_serial_add_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, carry8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, carry2;
  logic [1:0] a2, b2, sum2;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8)
  );

  serial_add_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .Cin(cin2),
    .busy(busy2), .done(done2), .Sum(sum2), .Carry(carry2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles spent busy until done appears (bounded).
  task automatic wait8(output int bc);
    bc = 0;
    while (busy8 && !done8 && bc < 20) begin
      bc++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 0; start2 = 0;
    a8 = 0; b8 = 0; cin8 = 0; a2 = 0; b2 = 0; cin2 = 0;
    tick(); tick(); tick();
    total++;
    if ({busy8, done8, carry8, sum8} !== 11'd0)
      $display("FAIL reset8 got busy=%b done=%b carry=%b sum=%h want all 0", busy8, done8, carry8, sum8);
    else passed++;
    total++;
    if ({busy2, done2, carry2, sum2} !== 5'd0)
      $display("FAIL reset2 got busy=%b done=%b carry=%b sum=%h want all 0", busy2, done2, carry2, sum2);
    else passed++;
  endtask

  task automatic test_first_start();
    int bc;
    rst = 1'b0; a8 = 8'h02; b8 = 8'h03; cin8 = 0; start8 = 1;
    tick();
    start8 = 0;
    total++;
    if (busy8 !== 1'b1) $display("FAIL first_start_busy got %b want 1", busy8);
    else passed++;
    wait8(bc);
    total++;
    if (done8 !== 1'b1 || sum8 !== 8'h05 || carry8 !== 1'b0)
      $display("FAIL first_start_result got done=%b sum=%h carry=%b want 1/05/0", done8, sum8, carry8);
    else passed++;
    tick();
  endtask

  task automatic test_basic();
    int bc;
    a8 = 8'hA5; b8 = 8'h3C; cin8 = 1; start8 = 1;
    tick();
    start8 = 0;
    wait8(bc);
    total++;
    if (bc !== 4) $display("FAIL basic_latency got %0d busy cycles want 4", bc);
    else passed++;
    total++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) $display("FAIL basic_done got done=%b busy=%b want 1/0", done8, busy8);
    else passed++;
    total++;
    if (sum8 !== 8'hE2 || carry8 !== 1'b0) $display("FAIL basic_result got %b/%h want 0/e2", carry8, sum8);
    else passed++;
    tick();
    total++;
    if (done8 !== 1'b0 || sum8 !== 8'hE2 || carry8 !== 1'b0)
      $display("FAIL basic_hold got done=%b sum=%h carry=%b want 0/e2/0", done8, sum8, carry8);
    else passed++;
  endtask

  task automatic test_ripple();
    int bc;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 0; start8 = 1;
    tick();
    start8 = 0;
    wait8(bc);
    total++;
    if (bc !== 4 || done8 !== 1'b1 || sum8 !== 8'h00 || carry8 !== 1'b1)
      $display("FAIL ripple got cycles=%0d done=%b %b/%h want 4 1 1/00", bc, done8, carry8, sum8);
    else passed++;
    tick();
  endtask

  task automatic test_operand_change();
    int bc;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1; start8 = 1;
    tick();
    start8 = 0;
    tick();
    a8 = 8'h00; b8 = 8'h00; cin8 = 0;
    wait8(bc);
    total++;
    if (done8 !== 1'b1 || sum8 !== 8'hFF || carry8 !== 1'b1)
      $display("FAIL operand_change got done=%b %b/%h want 1 1/ff", done8, carry8, sum8);
    else passed++;
    tick();
  endtask

  task automatic test_held_start();
    logic exp_done;
    a8 = 8'h02; b8 = 8'h03; cin8 = 0; start8 = 1;
    tick();
    for (int k = 0; k < 15; k++) begin
      exp_done = ((k % 5) == 4);
      total++;
      if (done8 !== exp_done || busy8 !== !exp_done)
        $display("FAIL held_start_k%0d got done=%b busy=%b want %b/%b", k, done8, busy8, exp_done, !exp_done);
      else passed++;
      if (exp_done) begin
        total++;
        if (sum8 !== 8'h05 || carry8 !== 1'b0) $display("FAIL held_start_sum_k%0d got %b/%h want 0/05", k, carry8, sum8);
        else passed++;
      end
      if (k < 14) tick();
    end
    start8 = 0;
    tick();
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) $display("FAIL held_start_idle got busy=%b done=%b want 0/0", busy8, done8);
    else passed++;
  endtask

  task automatic test_reset_abort();
    int dones;
    a8 = 8'hA5; b8 = 8'h3C; cin8 = 1; start8 = 1;
    tick();
    start8 = 0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy8, done8, carry8, sum8} !== 11'd0)
      $display("FAIL abort_state got busy=%b done=%b carry=%b sum=%h want all 0", busy8, done8, carry8, sum8);
    else passed++;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done8 || busy8) dones++;
      tick();
    end
    total++;
    if (dones !== 0) $display("FAIL abort_no_done got %0d active cycles want 0", dones);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int bc;
    a8 = 8'hA5; b8 = 8'h3C; cin8 = 1; start8 = 1;
    tick();
    start8 = 0;
    wait8(bc);
    total++;
    if (done8 !== 1'b1 || sum8 !== 8'hE2 || carry8 !== 1'b0)
      $display("FAIL b2b_first got done=%b %b/%h want 1 0/e2", done8, carry8, sum8);
    else passed++;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1; start8 = 1;
    tick();
    start8 = 0;
    total++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) $display("FAIL b2b_accept got busy=%b done=%b want 1/0", busy8, done8);
    else passed++;
    wait8(bc);
    total++;
    if (bc !== 4 || done8 !== 1'b1 || sum8 !== 8'h31 || carry8 !== 1'b0)
      $display("FAIL b2b_second got cycles=%0d done=%b %b/%h want 4 1 0/31", bc, done8, carry8, sum8);
    else passed++;
    tick();
  endtask

  task automatic test_random8();
    logic [7:0] a, b;
    logic       c, ovl;
    logic [8:0] exp9;
    int         bc;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); c = 1'($urandom_range(0, 1));
      exp9 = {1'b0, a} + {1'b0, b} + {8'd0, c};
      a8 = a; b8 = b; cin8 = c; start8 = 1;
      tick();
      start8 = 0;
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255)); cin8 = 1'($urandom_range(0, 1));
      bc = 0; ovl = 0;
      while (busy8 && !done8 && bc < 20) begin
        bc++;
        tick();
        if (busy8 && done8) ovl = 1;
      end
      total++;
      if ({carry8, sum8} !== exp9 || bc !== 4 || done8 !== 1'b1 || ovl)
        $display("FAIL rand8_%0d %h+%h+%b got %h cycles=%0d ovl=%b want %h cycles=4", i, a, b, c, {carry8, sum8}, bc, ovl, exp9);
      else passed++;
      tick();
    end
  endtask

  task automatic test_random2();
    logic [1:0] a, b;
    logic       c;
    logic [2:0] exp3;
    int         bc;
    for (int i = 0; i < 1000; i++) begin
      a = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1));
      exp3 = {1'b0, a} + {1'b0, b} + {2'd0, c};
      a2 = a; b2 = b; cin2 = c; start2 = 1;
      tick();
      start2 = 0;
      a2 = 2'($urandom_range(0, 3)); b2 = 2'($urandom_range(0, 3));
      bc = 0;
      while (busy2 && !done2 && bc < 20) begin
        bc++;
        tick();
      end
      total++;
      if ({carry2, sum2} !== exp3 || bc !== 1 || done2 !== 1'b1 || busy2 !== 1'b0)
        $display("FAIL rand2_%0d %h+%h+%b got %h cycles=%0d want %h cycles=1", i, a, b, c, {carry2, sum2}, bc, exp3);
      else passed++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_first_start();
    test_basic();
    test_ripple();
    test_operand_change();
    test_held_start();
    test_reset_abort();
    test_back_to_back();
    test_random8();
    test_random2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the value SHALL be even and at least 2.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-004 Port start, input, 1 bit, SHALL request a new addition.
REQ-005 Port A, input, WIDTH bits, SHALL be operand A.
REQ-006 Port B, input, WIDTH bits, SHALL be operand B.
REQ-007 Port Cin, input, 1 bit, SHALL be the carry-in.
REQ-008 Port busy, output, 1 bit, SHALL indicate that an addition is in progress.
REQ-009 Port done, output, 1 bit, SHALL be a one-cycle completion pulse.
REQ-010 Port Sum, output, WIDTH bits, SHALL be the registered result.
REQ-011 Port Carry, output, 1 bit, SHALL be the registered carry-out.

Function
REQ-012 The block SHALL add A+B+Cin two bits (one digit) per cycle, LSB digit first, over NDIG = WIDTH/2 cycles.
REQ-013 Each digit SHALL be added by an instance of full_adder_2bit, with the carry registered between digits.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE: when start=1 at a clock edge, the block SHALL latch A, B and Cin, clear the digit index to 0, and go to RUN.
REQ-016 RUN: each edge SHALL write the sum digit at the current index into the result register and update the carry register.
REQ-017 RUN: after writing digit NDIG-1, the block SHALL go to DONE; otherwise it SHALL increment the index.
REQ-018 DONE SHALL last exactly one cycle; with start=0 it SHALL return to IDLE.
REQ-019 DONE with start=1 SHALL be treated as IDLE acceptance: the block SHALL latch new operands and go to RUN.
REQ-020 Timing: with start accepted at edge t, busy SHALL be 1 for the cycles following edges t through t+NDIG-1.
REQ-021 Timing: with start accepted at edge t, done SHALL be 1 only for the cycle following edge t+NDIG.
REQ-022 Latency from the start edge to done SHALL be NDIG cycles, which is 4 for WIDTH=8.
REQ-023 start while in RUN SHALL be ignored; the in-flight operation SHALL be unaffected, and a held-high start SHALL be re-accepted only in DONE.
REQ-024 Operand port changes after acceptance SHALL NOT affect the result.
REQ-025 Sum and Carry SHALL be valid when done=1 and SHALL hold that value until the next accepted start.
REQ-026 Sum and Carry MAY change digit-by-digit while busy=1 and SHALL NOT be relied on during that time.
REQ-027 Result arithmetic SHALL satisfy {Carry,Sum} = A+B+Cin modulo 2^(WIDTH+1), i.e. no overflow loss.
REQ-028 busy and done SHALL never be 1 in the same cycle.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, busy=0, done=0, Sum=0, Carry=0, digit index=0, and cleared operand and carry latches.
REQ-030 rst SHALL take priority over start and over any in-progress RUN or DONE.
REQ-031 An aborted operation SHALL produce no done pulse.
REQ-032 The first start SHALL be accepted at the first edge where rst=0.

Verification
REQ-033 The bench SHALL cover: WIDTH=8, A=8'hA5, B=8'h3C, Cin=1, start pulsed at edge t -> busy for 4 cycles, done in the cycle after edge t+4, Sum=8'hE2, Carry=0.
REQ-034 The bench SHALL cover: A=8'hFF, B=8'h01, Cin=0 -> carry ripples through all digits, Sum=8'h00, Carry=1.
REQ-035 The bench SHALL cover: A=8'hFF, B=8'hFF, Cin=1, with A and B changed to 8'h00 during RUN -> Sum=8'hFF, Carry=1.
REQ-036 The bench SHALL cover: start held high continuously with A=8'h02, B=8'h03, Cin=0 -> done every 5th cycle, Sum=8'h05 each time, start ignored during RUN.
REQ-037 The bench SHALL cover: rst asserted at edge t+2 of an operation -> busy=0, done=0, Sum=0, Carry=0 after that edge, and no done pulse follows.
REQ-038 The bench SHALL cover: a back-to-back start in the DONE cycle with A=8'h10, B=8'h20, Cin=1 -> the first result is visible during DONE, and the second done follows 4 cycles later with Sum=8'h31, Carry=0.
REQ-039 The bench SHALL cover a random self-check of at least 1000 operations at WIDTH=8 and WIDTH=2 against {Carry,Sum} = A+B+Cin.
